lcd1602_reader: RTL and testbench
=================================

Name: lcd1602_reader

Overview:
HD44780/1602 read-cycle engine, the read-side complement of the write-only LCD driver.
- Issues RS/RW/EN read transactions and samples the LCD data bus.
- Returns either the busy flag and address counter (RS=0) or one DDRAM/CGRAM data byte (RS=1).
- Sits beside the LCD writer; the top level muxes RS/EN and tri-states DAT while this block owns the bus.

Parameters:
T_AS, 2, clk cycles RS/RW setup before EN rises (min 1)
T_EN, 16, clk cycles EN held high; the bus is sampled on the last one (min 2)
T_H, 2, clk cycles RS/RW hold after EN falls (min 1)
POLL_MAX, 255, max busy reads per poll request (used only with LCD_RD_POLL_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  read request
req_ready  out  1  high when state is IDLE
req_rs  in  1  0 = busy/address read, 1 = data read
req_poll  in  1  poll until not busy (ignored unless LCD_RD_POLL_EN)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_data  out  8  raw sampled byte
rsp_busy  out  1  rsp_data[7] when rs=0, else 0
rsp_addr  out  7  rsp_data[6:0] when rs=0, else 0
rsp_timeout  out  1  poll exhausted (0 without LCD_RD_POLL_EN)
lcd_rs  out  1  register select
lcd_rw  out  1  1 = read
lcd_en  out  1  enable strobe
lcd_dat_in  in  8  LCD data bus input
lcd_bus_own  out  1  1 = top must release DAT and select this block's RS/EN

Behaviour:
- Reset (async, any state): state IDLE; lcd_en=0, lcd_rw=0, lcd_rs=0, lcd_bus_own=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, req_ready=1.
- All outputs are registered; req_ready is decoded from the state register.
- States: IDLE -> SETUP -> EN_HI -> HOLD -> RESP -> IDLE.
- IDLE, on req_valid&&req_ready:
  - latch req_rs (and req_poll);
  - next edge enters SETUP with lcd_bus_own=1, lcd_rw=1, lcd_rs=latched rs, lcd_en=0.
- SETUP: T_AS cycles, then EN_HI.
- EN_HI: lcd_en=1 for T_EN cycles. lcd_dat_in is registered into rsp_data at the edge leaving EN_HI, while EN is still high.
- HOLD: lcd_en=0 and rs/rw are held for T_H cycles. On exit: lcd_rw=0, lcd_bus_own=0.
- RESP: rsp_valid=1. rsp_* are stable until the rsp_valid&&rsp_ready edge, then return to IDLE. rsp_valid drops on that edge.
- Latency: rsp_valid rises exactly T_AS+T_EN+T_H+1 edges after the accept edge. Back-to-back throughput is one transaction per T_AS+T_EN+T_H+2 cycles.
- req_valid while not IDLE is ignored (req_ready=0). A request held across RESP is accepted on the first IDLE cycle.
- The phase counter is a down-counter loaded with (phase length − 1) on phase entry. A phase exits when the count is 0. No wrap.
- rsp_busy and rsp_addr are forced to 0 for data reads.
- Reset asserted mid-EN_HI: lcd_en falls asynchronously and no response is produced.

Optional Feature:
Macro: LCD_RD_POLL_EN.
- Defined:
  - A request with req_poll=1 forces rs=0 and loops SETUP->EN_HI->HOLD while the sampled bit 7 is 1.
  - A 0 sample goes to RESP with rsp_timeout=0.
  - After POLL_MAX reads with bit 7 still 1, it goes to RESP with rsp_timeout=1 and rsp_busy=1.
  - lcd_bus_own stays 1 across loop iterations; it drops only at final HOLD exit.
  - The poll counter is 8 bits and saturating.
- Undefined: req_poll is ignored, there is no poll counter, and rsp_timeout is tied to 0.

Decomposition:
- Package lcd1602_pkg:
  - state enum (IDLE, SETUP, EN_HI, HOLD, RESP);
  - HD44780 field constants BF_BIT=7, AC_MSB=6;
  - RS_INSTR=0, RS_DATA=1;
  - default timing constants shared with the writer.
- One sub-module, lcd_phase_timer: loadable down-counter with load value and done flag. It is reusable by the writer.

Test Plan:
1. Reset mid-EN_HI -> lcd_en=0, lcd_bus_own=0, rsp_valid=0 immediately. First request after release completes normally.
2. Busy read with lcd_dat_in=8'h85 -> lcd_rs=0 and lcd_rw=1 for 20 cycles, EN high for exactly 16 cycles. rsp_valid rises at edge 21 after accept; rsp_busy=1, rsp_addr=7'h05.
3. Data read with lcd_dat_in=8'h57 ("W") -> lcd_rs=1, rsp_data=8'h57, rsp_busy=0, rsp_addr=0.
4. rsp_ready held low for 10 cycles, new req_valid pending -> response stable, req_ready=0. New transaction accepted on the cycle after the handshake.
5. lcd_dat_in changes at EN_HI cycle 15 from 8'hAA to 8'h55 -> rsp_data=8'h55, because sampling is on the last EN-high cycle.
6. With LCD_RD_POLL_EN, bus bit 7 = 1 for 3 reads then 8'h10 -> 4 EN pulses, rsp_busy=0, rsp_addr=7'h10, rsp_timeout=0. Bit 7 stuck at 1 -> 255 pulses, then rsp_timeout=1.

Source files
------------

// File: rtl/lcd1602_pkg.sv
// Shared HD44780 constants, FSM state encoding and default bus timing for the
// LCD reader and writer.
package lcd1602_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HI,
        HOLD,
        RESP
    } rd_state_e;

    localparam int BF_BIT = 7;
    localparam int AC_MSB = 6;

    localparam logic RS_INSTR = 1'b0;
    localparam logic RS_DATA  = 1'b1;

    localparam int DEF_T_AS     = 2;
    localparam int DEF_T_EN     = 16;
    localparam int DEF_T_H      = 2;
    localparam int DEF_POLL_MAX = 255;

    localparam int PH_W = 8;

    // Phase counters count down to zero, so a phase of len cycles loads len-1.
    function automatic logic [PH_W-1:0] phase_load(input int len);
        return PH_W'(len - 1);
    endfunction

endpackage

// File: rtl/lcd1602_reader_if.sv
// Request/response handshake between a host and the LCD read-cycle engine.
interface lcd1602_reader_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic       req_poll;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_busy;
    logic [6:0] rsp_addr;
    logic       rsp_timeout;

    modport master (
        output req_valid, req_rs, req_poll, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_busy, rsp_addr, rsp_timeout
    );

    modport slave (
        input  req_valid, req_rs, req_poll, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_busy, rsp_addr, rsp_timeout
    );
endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter timing one bus phase; done while the count is zero.
module lcd_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/lcd1602_reader.sv
// HD44780 read-cycle engine: busy/address or data-byte reads over RS/RW/EN.
// Define LCD_RD_POLL_EN to enable hardware busy-flag polling.
module lcd1602_reader
    import lcd1602_pkg::*;
#(
    parameter int T_AS     = DEF_T_AS,
    parameter int T_EN     = DEF_T_EN,
    parameter int T_H      = DEF_T_H,
    parameter int POLL_MAX = DEF_POLL_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd1602_reader_if.slave   bus,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_en,
    input  logic [7:0]        lcd_dat_in,
    output logic              lcd_bus_own
);
    rd_state_e   state_q, state_d;
    logic        rs_q, rs_d, rw_q, rw_d, en_q, en_d, own_q, own_d;
    logic        vld_q, vld_d, busy_q, busy_d;
    logic [7:0]  data_q, data_d;
    logic [6:0]  addr_q, addr_d;
    logic            ph_load, ph_done;
    logic [PH_W-1:0] ph_val;
    logic        loop_again;

    lcd_phase_timer #(.W(PH_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .done_o     (ph_done)
    );

`ifdef LCD_RD_POLL_EN
    localparam logic [7:0] POLL_MAX_C = 8'(POLL_MAX);
    logic       poll_q, poll_d, tout_q, tout_d;
    logic [7:0] pcnt_q, pcnt_d;

    // Keep reading while still busy and the read budget is not used up.
    assign loop_again      = poll_q && data_q[BF_BIT] && (pcnt_q < POLL_MAX_C);
    assign bus.rsp_timeout = tout_q;
`else
    logic unused_poll;
    assign unused_poll     = bus.req_poll ^ POLL_MAX[0];
    assign loop_again      = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        rw_d    = rw_q;
        en_d    = en_q;
        own_d   = own_q;
        vld_d   = vld_q;
        data_d  = data_q;
        busy_d  = busy_q;
        addr_d  = addr_q;
        ph_load = 1'b0;
        ph_val  = '0;
`ifdef LCD_RD_POLL_EN
        poll_d  = poll_q;
        pcnt_d  = pcnt_q;
        tout_d  = tout_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = SETUP;
                    own_d   = 1'b1;
                    rw_d    = 1'b1;
                    en_d    = 1'b0;
                    ph_load = 1'b1;
                    ph_val  = phase_load(T_AS);
`ifdef LCD_RD_POLL_EN
                    poll_d  = bus.req_poll;
                    pcnt_d  = '0;
                    tout_d  = 1'b0;
                    rs_d    = bus.req_poll ? RS_INSTR : bus.req_rs;
`else
                    rs_d    = bus.req_rs;
`endif
                end
            end
            SETUP: begin
                if (ph_done) begin
                    state_d = EN_HI;
                    en_d    = 1'b1;
                    ph_load = 1'b1;
                    ph_val  = phase_load(T_EN);
                end
            end
            EN_HI: begin
                if (ph_done) begin
                    // EN is still high on this edge, so the bus is valid here.
                    state_d = HOLD;
                    en_d    = 1'b0;
                    data_d  = lcd_dat_in;
                    busy_d  = (rs_q == RS_INSTR) && lcd_dat_in[BF_BIT];
                    addr_d  = (rs_q == RS_INSTR) ? lcd_dat_in[AC_MSB:0] : 7'd0;
                    ph_load = 1'b1;
                    ph_val  = phase_load(T_H);
`ifdef LCD_RD_POLL_EN
                    if (poll_q && pcnt_q != 8'hFF) pcnt_d = pcnt_q + 8'd1;
`endif
                end
            end
            HOLD: begin
                if (ph_done) begin
                    if (loop_again) begin
                        state_d = SETUP;
                        ph_load = 1'b1;
                        ph_val  = phase_load(T_AS);
                    end else begin
                        state_d = RESP;
                        rw_d    = 1'b0;
                        rs_d    = 1'b0;
                        own_d   = 1'b0;
                        vld_d   = 1'b1;
`ifdef LCD_RD_POLL_EN
                        tout_d  = poll_q && data_q[BF_BIT];
`endif
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            en_q    <= 1'b0;
            own_q   <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
`ifdef LCD_RD_POLL_EN
            poll_q  <= 1'b0;
            pcnt_q  <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            en_q    <= en_d;
            own_q   <= own_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
`ifdef LCD_RD_POLL_EN
            poll_q  <= poll_d;
            pcnt_q  <= pcnt_d;
            tout_q  <= tout_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_busy  = busy_q;
    assign bus.rsp_addr  = addr_q;
    assign lcd_rs        = rs_q;
    assign lcd_rw        = rw_q;
    assign lcd_en        = en_q;
    assign lcd_bus_own   = own_q;
endmodule

// File: tb/tb_lcd1602_reader.sv
// Self-checking bench for lcd1602_reader: directed and random read cycles
// against a cycle-count and field-decode reference model.
module tb_lcd1602_reader;
    localparam int T_AS = 2, T_EN = 16, T_H = 2;
    localparam int LAT  = T_AS + T_EN + T_H + 1;   // accept edge counted as edge 1
    localparam int PER  = T_AS + T_EN + T_H + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_bus_own;
    logic [7:0] lcd_dat_in = 8'h00;
    int         checks = 0;
    int         errors = 0;

    lcd1602_reader_if bus();

    lcd1602_reader #(.T_AS(T_AS), .T_EN(T_EN), .T_H(T_H), .POLL_MAX(255)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_en      (lcd_en),
        .lcd_dat_in  (lcd_dat_in),
        .lcd_bus_own (lcd_bus_own)
    );

    always #5 clk = ~clk;

    // One read: d0 on the bus, d1 only in the final EN-high cycle, ~d1 after EN falls.
    task automatic run_read(input logic rs, input logic [7:0] d0, input logic [7:0] d1,
                            input int dly, input logic keep, input string tag,
                            output time t_acc);
        int lat = 0, en_cnt = 0, rw_cnt = 0, rs_bad = 0;
        logic       exp_busy;
        logic [6:0] exp_addr;
        exp_busy = (rs == 1'b0) ? d1[7] : 1'b0;
        exp_addr = (rs == 1'b0) ? d1[6:0] : 7'h00;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL %s start_ready: got %b want 1", tag, bus.req_ready);
        end
        t_acc = $time;
        bus.req_valid = 1'b1; bus.req_rs = rs; bus.req_poll = 1'b0; lcd_dat_in = d0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = keep;
            if (bus.rsp_valid) begin lat = k; break; end
            if (lcd_rw) begin
                rw_cnt++;
                if (lcd_rs !== rs || lcd_bus_own !== 1'b1) rs_bad++;
            end
            if (lcd_en) begin
                en_cnt++;
                if (en_cnt == T_EN) lcd_dat_in = d1;
            end else if (en_cnt == T_EN) lcd_dat_in = ~d1;
        end
        checks++;
        if (lat != LAT) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, LAT);
        end
        checks++;
        if (en_cnt != T_EN) begin
            errors++; $display("FAIL %s en_cycles: got %0d want %0d", tag, en_cnt, T_EN);
        end
        checks++;
        if (rw_cnt != T_AS + T_EN + T_H || rs_bad != 0) begin
            errors++; $display("FAIL %s rw_window: got %0d cycles (%0d bad) want %0d", tag, rw_cnt, rs_bad, T_AS+T_EN+T_H);
        end
        for (int c = 0; c <= dly; c++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d1 || bus.rsp_busy !== exp_busy ||
                bus.rsp_addr !== exp_addr || bus.rsp_timeout !== 1'b0 || bus.req_ready !== 1'b0 ||
                lcd_bus_own !== 1'b0 || lcd_rw !== 1'b0) begin
                errors++;
                $display("FAIL %s response: got v=%b d=%h b=%b a=%h t=%b rdy=%b own=%b want v=1 d=%h b=%b a=%h t=0 rdy=0 own=0",
                         tag, bus.rsp_valid, bus.rsp_data, bus.rsp_busy, bus.rsp_addr, bus.rsp_timeout,
                         bus.req_ready, lcd_bus_own, d1, exp_busy, exp_addr);
            end
            if (c < dly) @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL %s handshake: got v=%b rdy=%b want v=0 rdy=1", tag, bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (lcd_en !== 1'b0 || lcd_rw !== 1'b0 || lcd_rs !== 1'b0 || lcd_bus_own !== 1'b0 ||
            bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00 || bus.rsp_timeout !== 1'b0 ||
            bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got en=%b rw=%b rs=%b own=%b v=%b d=%h t=%b rdy=%b want 0,0,0,0,0,00,0,1",
                     lcd_en, lcd_rw, lcd_rs, lcd_bus_own, bus.rsp_valid, bus.rsp_data, bus.rsp_timeout, bus.req_ready);
        end
    endtask

    task automatic test_reset_mid_en();
        int saw_vld = 0, waited = 0;
        time t;
        bus.req_valid = 1'b1; bus.req_rs = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (!lcd_en && waited < 40) begin @(negedge clk); waited++; end
        repeat (5) @(negedge clk);
        checks++;
        if (lcd_en !== 1'b1) begin
            errors++; $display("FAIL mid_en_reached: got en=%b want 1", lcd_en);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (lcd_en !== 1'b0 || lcd_bus_own !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset: got en=%b own=%b v=%b rdy=%b want 0,0,0,1",
                               lcd_en, lcd_bus_own, bus.rsp_valid, bus.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin @(negedge clk); if (bus.rsp_valid) saw_vld++; end
        checks++;
        if (saw_vld != 0) begin
            errors++; $display("FAIL no_resp_after_reset: got %0d valid cycles want 0", saw_vld);
        end
        run_read(1'b0, 8'h23, 8'h23, 0, 1'b0, "after_reset", t);
    endtask

    task automatic test_busy_read();
        time t;
        run_read(1'b0, 8'h85, 8'h85, 0, 1'b0, "busy_85", t);
    endtask

    task automatic test_data_read();
        time t;
        run_read(1'b1, 8'h57, 8'h57, 2, 1'b0, "data_57", t);
    endtask

    task automatic test_late_sample();
        time t;
        run_read(1'b1, 8'hAA, 8'h55, 0, 1'b0, "late_55", t);
    endtask

    task automatic test_back_to_back();
        time t1, t2, t3;
        run_read(1'b0, 8'h3C, 8'h3C, 10, 1'b1, "b2b_stall", t1);
        run_read(1'b1, 8'hC3, 8'hC3, 0, 1'b1, "b2b_next", t2);
        run_read(1'b0, 8'h7E, 8'h7E, 0, 1'b0, "b2b_last", t3);
        bus.req_valid = 1'b0;
        checks++;
        if (t2 - t1 != (PER + 10) * 10) begin
            errors++; $display("FAIL b2b_stall_gap: got %0t want %0d", t2 - t1, (PER + 10) * 10);
        end
        checks++;
        if (t3 - t2 != PER * 10) begin
            errors++; $display("FAIL b2b_period: got %0t want %0d", t3 - t2, PER * 10);
        end
    endtask

    task automatic test_random();
        time t;
        for (int i = 0; i < 8; i++) begin
            run_read(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                     int'($urandom_range(0, 4)), 1'b0, "random", t);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

`ifdef LCD_RD_POLL_EN
    task automatic test_poll(input int nbusy, input logic [7:0] fin, input int exp_pulses,
                             input logic exp_tout, input string tag);
        int pulses = 0, bad = 0, done = 0;
        logic prev_en = 1'b0;
        lcd_dat_in = (nbusy > 0) ? (8'h80 | 8'($urandom)) : fin;
        bus.req_valid = 1'b1; bus.req_rs = 1'b1; bus.req_poll = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_poll = 1'b0;
        for (int k = 0; k < 7000; k++) begin
            if (bus.rsp_valid) begin done = 1; break; end
            if (lcd_rs !== 1'b0 || lcd_bus_own !== 1'b1) bad++;
            if (lcd_en && !prev_en) pulses++;
            if (!lcd_en && prev_en) lcd_dat_in = (pulses < nbusy) ? (8'h80 | 8'($urandom)) : fin;
            prev_en = lcd_en;
            @(negedge clk);
        end
        checks++;
        if (done == 0 || pulses != exp_pulses || bad != 0) begin
            errors++; $display("FAIL %s pulses: got %0d (done=%0d bad=%0d) want %0d", tag, pulses, done, bad, exp_pulses);
        end
        checks++;
        if (bus.rsp_timeout !== exp_tout || bus.rsp_busy !== exp_tout ||
            (!exp_tout && bus.rsp_addr !== fin[6:0])) begin
            errors++; $display("FAIL %s result: got t=%b b=%b a=%h want t=%b b=%b a=%h", tag,
                               bus.rsp_timeout, bus.rsp_busy, bus.rsp_addr, exp_tout, exp_tout, fin[6:0]);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        bus.req_valid = 1'b0; bus.req_rs = 1'b0; bus.req_poll = 1'b0; bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_busy_read();
        test_data_read();
        test_late_sample();
        test_back_to_back();
        test_reset_mid_en();
        test_random();
`ifdef LCD_RD_POLL_EN
        test_poll(3, 8'h10, 4, 1'b0, "poll_3");
        test_poll(10000, 8'h10, 255, 1'b1, "poll_stuck");
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
